// File: rtl/isa_pkg.sv
// ALU op encoding plus the issue-stage occupancy states and pipeline-register payloads
// shared by fu_alu_issue and its neighbours.
package isa_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Occupancy of the E (execute) and W (writeback) registers
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    E_ONLY = 2'd1,
    W_ONLY = 2'd2,
    FULL   = 2'd3
  } fu_issue_state_t;

  // Execute-stage payload: what the ALU sees
  typedef struct packed {
    aluop_t            aluop;
    logic [XLEN-1:0]   port_a;
    logic [XLEN-1:0]   port_b;
    logic [REG_W-1:0]  rd;
  } e_stage_t;

  // Writeback-stage payload; ovf marks an ADD/SUB overflow for the counter
  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic              zero;
    logic              negative;
    logic              ovf;
    logic              exc;
    logic              we;
    logic [REG_W-1:0]  rd;
  } w_stage_t;

  // Only ADD/SUB produce a meaningful signed-overflow indication
  function automatic logic is_addsub(input aluop_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage : isa_pkg

// File: rtl/fu_alu_issue.sv
// ALU functional-unit issue/writeback wrapper.
// Takes decoded ALU ops from dispatch (in_*), holds them in an execute register that
// drives the external combinational ALU (alu_*), and captures the ALU result and flags
// into a writeback register offered to the register file (wb_*).
// Ports:
//   CLK, rst            clock, synchronous active-high reset
//   flush               discard every in-flight op
//   in_*                dispatch valid/ready op interface
//   alu_*               connection to the fu_alu_if alu modport
//   wb_*                writeback valid/ready result interface
//   ops_retired         wrapping count of writeback handshakes
//   ovf_count           saturating count of retired ADD/SUB overflows
module fu_alu_issue
  import isa_pkg::*;
#(
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRAP_ON_OVF = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  aluop_t            in_aluop,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [TAG_W-1:0]  in_tag,

  output logic              alu_enable,
  output aluop_t            alu_aluop,
  output logic [XLEN-1:0]   alu_port_a,
  output logic [XLEN-1:0]   alu_port_b,
  input  logic [XLEN-1:0]   alu_port_output,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_negative,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_we,
  output logic              wb_exc,
  output logic              wb_zero,
  output logic              wb_negative,
  output logic [TAG_W-1:0]  wb_tag,

  output logic [CNT_W-1:0]  ops_retired,
  output logic [CNT_W-1:0]  ovf_count
);

  fu_issue_state_t    r_state;
  fu_issue_state_t    w_state_nxt;
  e_stage_t           r_e;
  w_stage_t           r_w;
  logic [TAG_W-1:0]   r_e_tag;
  logic [TAG_W-1:0]   r_w_tag;
  logic [CNT_W-1:0]   r_ops_retired;
  logic [CNT_W-1:0]   r_ovf_count;

  logic               w_e_valid;
  logic               w_w_valid;
  logic               w_adv;
  logic               w_accept;
  logic               w_retire;
  logic               w_e_nxt;
  logic               w_w_nxt;
  logic               w_ovf;
  logic               w_exc;
  logic [XLEN-1:0]    w_opb;

  // Stage valids are decoded from the occupancy state
  assign w_e_valid = (r_state == E_ONLY) || (r_state == FULL);
  assign w_w_valid = (r_state == W_ONLY) || (r_state == FULL);

  // E moves into W whenever W is free or being drained this cycle
  assign w_adv    = w_e_valid && (!w_w_valid || wb_ready);
  assign in_ready = !flush && (!w_e_valid || w_adv);
  assign w_accept = in_valid && in_ready;
  assign w_retire = w_w_valid && wb_ready;

  assign w_opb = in_use_imm ? in_imm : in_rs2_val;

  // Overflow is only meaningful for ADD/SUB; trapping is a build-time choice
  assign w_ovf = alu_overflow && is_addsub(r_e.aluop);
  assign w_exc = (TRAP_ON_OVF != 0) && w_ovf;

  // Occupancy next-state; flush empties both stages
  always_comb begin
    w_e_nxt     = 1'b0;
    w_w_nxt     = 1'b0;
    w_state_nxt = r_state;
    if (!flush) begin
      w_e_nxt = w_accept || (w_e_valid && !w_adv);
      w_w_nxt = w_adv || (w_w_valid && !wb_ready);
    end
    case ({w_w_nxt, w_e_nxt})
      2'b00:   w_state_nxt = EMPTY;
      2'b01:   w_state_nxt = E_ONLY;
      2'b10:   w_state_nxt = W_ONLY;
      default: w_state_nxt = FULL;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Execute-stage register
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_e     <= '0;
      r_e_tag <= '0;
    end else if (w_accept) begin
      r_e.aluop  <= in_aluop;
      r_e.port_a <= in_rs1_val;
      r_e.port_b <= w_opb;
      r_e.rd     <= in_rd;
      r_e_tag    <= in_tag;
    end
  end

  // Writeback-stage register; an excepting op never writes the register file
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_w     <= '0;
      r_w_tag <= '0;
    end else if (w_adv && !flush) begin
      r_w.data     <= alu_port_output;
      r_w.zero     <= alu_zero;
      r_w.negative <= alu_negative;
      r_w.ovf      <= w_ovf;
      r_w.exc      <= w_exc;
      r_w.we       <= (r_e.rd != REG_W'(0)) && !w_exc;
      r_w.rd       <= r_e.rd;
      r_w_tag      <= r_e_tag;
    end
  end

  // Performance counters; a handshake coinciding with flush still counts
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_ops_retired <= '0;
      r_ovf_count   <= '0;
    end else if (w_retire) begin
      r_ops_retired <= r_ops_retired + CNT_W'(1);
      if (r_w.ovf && (r_ovf_count != {CNT_W{1'b1}})) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

  // ALU drive is quiet (all zero) while E is empty
  assign alu_enable = w_e_valid;
  assign alu_aluop  = w_e_valid ? r_e.aluop  : aluop_t'(4'd0);
  assign alu_port_a = w_e_valid ? r_e.port_a : XLEN'(0);
  assign alu_port_b = w_e_valid ? r_e.port_b : XLEN'(0);

  assign wb_valid    = w_w_valid;
  assign wb_rd       = r_w.rd;
  assign wb_data     = r_w.data;
  assign wb_we       = r_w.we;
  assign wb_exc      = r_w.exc;
  assign wb_zero     = r_w.zero;
  assign wb_negative = r_w.negative;
  assign wb_tag      = r_w_tag;

  assign ops_retired = r_ops_retired;
  assign ovf_count   = r_ovf_count;

endmodule : fu_alu_issue

// File: tb/tb_fu_alu_issue.sv
// Bench for fu_alu_issue: a behavioural ALU answers the alu_* port, a scoreboard queue
// holds the expected writeback of every accepted op, and a table plus directed
// sequences cover back-to-back issue, stall, flush and reset.
module tb_fu_alu_issue;
  import isa_pkg::*;

  logic        CLK = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  aluop_t      in_aluop;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic [3:0]  in_tag;
  logic        alu_enable;
  aluop_t      alu_aluop;
  logic [31:0] alu_port_a, alu_port_b, alu_port_output;
  logic        alu_overflow, alu_zero, alu_negative;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we, wb_exc, wb_zero, wb_negative;
  logic [3:0]  wb_tag;
  logic [15:0] ops_retired, ovf_count;

  fu_alu_issue #(.TAG_W(4), .CNT_W(16), .TRAP_ON_OVF(1)) dut (
    .CLK(CLK), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd(in_rd), .in_tag(in_tag),
    .alu_enable(alu_enable), .alu_aluop(alu_aluop), .alu_port_a(alu_port_a),
    .alu_port_b(alu_port_b), .alu_port_output(alu_port_output),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_we(wb_we), .wb_exc(wb_exc), .wb_zero(wb_zero), .wb_negative(wb_negative),
    .wb_tag(wb_tag), .ops_retired(ops_retired), .ovf_count(ovf_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU standing in for the fu_alu_if slave
  logic [31:0] m_r;
  logic        m_v;
  always_comb begin
    m_r = 32'd0;
    m_v = 1'b0;
    case (alu_aluop)
      ALU_ADD: begin
        m_r = alu_port_a + alu_port_b;
        m_v = (alu_port_a[31] == alu_port_b[31]) && (m_r[31] != alu_port_a[31]);
      end
      ALU_SUB: begin
        m_r = alu_port_a - alu_port_b;
        m_v = (alu_port_a[31] != alu_port_b[31]) && (m_r[31] != alu_port_a[31]);
      end
      ALU_AND:  m_r = alu_port_a & alu_port_b;
      ALU_OR:   m_r = alu_port_a | alu_port_b;
      ALU_XOR:  m_r = alu_port_a ^ alu_port_b;
      ALU_SLL:  m_r = alu_port_a << alu_port_b[4:0];
      ALU_SRL:  m_r = alu_port_a >> alu_port_b[4:0];
      ALU_SRA:  m_r = 32'($signed(alu_port_a) >>> alu_port_b[4:0]);
      ALU_SLT:  m_r = {31'd0, $signed(alu_port_a) < $signed(alu_port_b)};
      ALU_SLTU: m_r = {31'd0, alu_port_a < alu_port_b};
      default:  m_r = 32'd0;
    endcase
  end
  assign alu_port_output = m_r;
  assign alu_overflow    = m_v;
  assign alu_zero        = (m_r == 32'd0);
  assign alu_negative    = m_r[31];

  typedef struct {
    aluop_t      op;
    logic [31:0] a, b, imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero, neg, exc, we, ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [3:0]  tag;
    logic        we, exc, zero, neg, ovf;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur_exp;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] m_ops  = 16'd0;
  logic [15:0] m_ovf  = 16'd0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: retire compares, accept pushes, flush/reset drop in-flight entries
  always @(negedge CLK) begin
    if (rst) begin
      sb_q.delete();
      m_ops = 16'd0;
      m_ovf = 16'd0;
    end else begin
      chk("ops_retired", 64'(ops_retired), 64'(m_ops));
      chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
      if (wb_valid && wb_ready) begin
        chk("wb_has_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wb_result{data,rd,tag,we,exc,zero,neg}",
              64'({wb_data, wb_rd, wb_tag, wb_we, wb_exc, wb_zero, wb_negative}),
              64'({e.data, e.rd, e.tag, e.we, e.exc, e.zero, e.neg}));
          m_ops = m_ops + 16'd1;
          if (e.ovf && (m_ovf != 16'hFFFF)) m_ovf = m_ovf + 16'd1;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
      if (flush) sb_q.delete();
    end
  end

  task automatic set_op(input vec_t v, input logic [3:0] tag);
    in_aluop   = v.op;
    in_rs1_val = v.a;
    in_rs2_val = v.b;
    in_imm     = v.imm;
    in_use_imm = v.use_imm;
    in_rd      = v.rd;
    in_tag     = tag;
    in_valid   = 1'b1;
    cur_exp    = '{data: v.data, rd: v.rd, tag: tag, we: v.we, exc: v.exc,
                   zero: v.zero, neg: v.neg, ovf: v.ovf};
  endtask

  // Hold the op until accepted (bounded); returns at posedge+1 after the accept edge
  task automatic wait_accept(input string name);
    bit acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge CLK);
      if (in_ready) acc = 1'b1;
      @(posedge CLK); #1;
    end
    chk(name, 64'(acc), 64'd1);
  endtask

  task automatic check_reset_state();
    @(negedge CLK);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_alu_enable", 64'(alu_enable), 64'd0);
    chk("rst_alu_aluop_a", 64'({alu_aluop, alu_port_a, alu_port_b[3:0]}), 64'd0);
    chk("rst_wb_data_we_exc", 64'({wb_data, wb_we, wb_exc, wb_rd}), 64'd0);
    chk("rst_counters", 64'({ops_retired, ovf_count}), 64'd0);
    @(posedge CLK); #1;
  endtask

  function automatic vec_t mk(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                              input logic [31:0] data, input logic zero, input logic neg,
                              input logic exc, input logic we, input logic ovf);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.use_imm = use_imm; v.rd = rd;
    v.data = data; v.zero = zero; v.neg = neg; v.exc = exc; v.we = we; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    logic [15:0] saved;
    vec_t v;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    in_aluop = ALU_ADD; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
    in_use_imm = 1'b0; in_rd = '0; in_tag = '0; cur_exp = '0;

    //            op        a             b             imm           imm rd     data          z  n  exc we ovf
    tbl[0] = mk(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'hDEAD0000, 0, 5'd5,  32'h80000000, 0, 1, 1, 0, 1);
    tbl[1] = mk(ALU_SUB,  32'd5,        32'd5,        32'hDEAD0000, 0, 5'd3,  32'h00000000, 1, 0, 0, 1, 0);
    tbl[2] = mk(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'hDEAD0000, 0, 5'd4,  32'h00000001, 0, 0, 0, 1, 0);
    tbl[3] = mk(ALU_ADD,  32'd10,       32'h12345678, 32'hFFFFFFFF, 1, 5'd0,  32'h00000009, 0, 0, 0, 0, 0);
    tbl[4] = mk(ALU_SUB,  32'h80000000, 32'h00000001, 32'hDEAD0000, 0, 5'd7,  32'h7FFFFFFF, 0, 0, 1, 0, 1);
    tbl[5] = mk(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hDEAD0000, 0, 5'd8,  32'hF000F000, 0, 1, 0, 1, 0);
    tbl[6] = mk(ALU_XOR,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEAD0000, 0, 5'd9,  32'h00000000, 1, 0, 0, 1, 0);
    tbl[7] = mk(ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'hDEAD0000, 0, 5'd10, 32'h00000001, 0, 0, 0, 1, 0);
    tbl[8] = mk(ALU_SLL,  32'h00000001, 32'h0000001F, 32'hDEAD0000, 0, 5'd11, 32'h80000000, 0, 1, 0, 1, 0);

    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    check_reset_state();

    // Back-to-back issue with wb_ready=1: ready every cycle, result one cycle after accept
    for (int i = 0; i < 9; i++) begin
      set_op(tbl[i], 4'(i));
      @(negedge CLK);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      chk("b2b_alu_enable", 64'(alu_enable), 64'(i > 0));
      chk("b2b_wb_valid", 64'(wb_valid), 64'(i > 1));
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("table_ops_retired", 64'(ops_retired), 64'd9);
    chk("table_ovf_count", 64'(ovf_count), 64'd2);
    chk("table_drained", 64'(wb_valid), 64'd0);
    @(posedge CLK); #1;

    // Stall: two ops fill E and W, third is held off, W stays put
    wb_ready = 1'b0;
    set_op(mk(ALU_OR,  32'h0000000F, 32'h000000F0, 0, 0, 5'd1,  32'h000000FF, 0, 0, 0, 1, 0), 4'd0);
    wait_accept("stall_op0_accept");
    set_op(mk(ALU_SRL, 32'h80000000, 32'd4,        0, 0, 5'd2,  32'h08000000, 0, 0, 0, 1, 0), 4'd1);
    wait_accept("stall_op1_accept");
    set_op(mk(ALU_SRA, 32'h80000000, 32'd4,        0, 0, 5'd12, 32'hF8000000, 0, 1, 0, 1, 0), 4'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_wb_hold{valid,tag,data}", 64'({wb_valid, wb_tag, wb_data}),
          64'({1'b1, 4'd0, 32'h000000FF}));
      @(posedge CLK); #1;
    end
    wb_ready = 1'b1;
    wait_accept("stall_op2_accept");
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Flush while FULL with an op offered: nothing accepted, nothing retired
    wb_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'd1, 32'd2, 0, 0, 5'd13, 32'h00000003, 0, 0, 0, 1, 0), 4'd3);
    wait_accept("flush_op0_accept");
    set_op(mk(ALU_SUB, 32'd0, 32'd1, 0, 0, 5'd14, 32'hFFFFFFFF, 0, 1, 0, 1, 0), 4'd4);
    wait_accept("flush_op1_accept");
    saved = m_ops;
    set_op(mk(ALU_ADD, 32'd9, 32'd9, 0, 0, 5'd15, 32'h00000012, 0, 0, 0, 1, 0), 4'd5);
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_full_wb_valid", 64'(wb_valid), 64'd1);
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("post_flush_valids{wb,alu_en}", 64'({wb_valid, alu_enable}), 64'd0);
    chk("post_flush_ops", 64'(ops_retired), 64'(saved));
    @(posedge CLK); #1;

    // Flush coinciding with a writeback handshake still counts the retire
    v = mk(ALU_ADD, 32'd100, 32'd200, 0, 0, 5'd15, 32'h0000012C, 0, 0, 0, 1, 0);
    set_op(v, 4'd6);
    wait_accept("flush_hs_accept");
    in_valid = 1'b0;
    @(posedge CLK); #1;
    saved = m_ops;
    flush = 1'b1; wb_ready = 1'b1;
    @(negedge CLK);
    chk("flush_hs_wb_valid", 64'(wb_valid), 64'd1);
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    chk("flush_hs_cleared", 64'(wb_valid), 64'd0);
    chk("flush_hs_ops", 64'(ops_retired), 64'(saved) + 64'd1);
    @(posedge CLK); #1;

    // Reset in the middle of an op returns to the reset state
    wb_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'h7FFFFFFF, 32'd1, 0, 0, 5'd6, 32'h80000000, 0, 1, 1, 0, 1), 4'd7);
    wait_accept("midrst_accept");
    in_valid = 1'b0;
    @(posedge CLK); #1;
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    check_reset_state();

    wb_ready = 1'b1;
    set_op(mk(ALU_ADD, 32'd2, 32'd3, 0, 0, 5'd1, 32'h00000005, 0, 0, 0, 1, 0), 4'd8);
    wait_accept("post_rst_accept");
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("post_rst_ops", 64'(ops_retired), 64'd1);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_fu_alu_issue
